// File: rtl/mdio_responder_if.sv
// Register-file side of the Clause 22 MDIO responder: address/data strobes and status.
// The responder uses the slave modport; the register file or harness uses master.
interface mdio_responder_if;
   logic [4:0]  reg_addr;
   logic        reg_wr;
   logic [15:0] reg_wdata;
   logic        reg_rd;
   logic [15:0] reg_rdata;
   logic        frame_err;
   logic        busy;

   modport slave (
      output reg_addr,
      output reg_wr,
      output reg_wdata,
      output reg_rd,
      input  reg_rdata,
      output frame_err,
      output busy
   );

   modport master (
      input  reg_addr,
      input  reg_wr,
      input  reg_wdata,
      input  reg_rd,
      output reg_rdata,
      input  frame_err,
      input  busy
   );
endinterface

// File: rtl/mdio_responder.sv
// PHY-side MDIO Clause 22 responder: oversamples MDC/MDIO, decodes frames, strobes a register file.
// Optional MDIO_RESP_BROADCAST_EN accepts PHY address 5'h00 for writes only.
module mdio_responder #(
   parameter logic [4:0]  PHY_ADDR     = 5'h01,
   parameter int unsigned PREAMBLE_MIN = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             mdc,
   inout  wire              mdio,
   mdio_responder_if.slave  bus
);

   localparam logic [5:0] PreMin = 6'(PREAMBLE_MIN);

   typedef enum logic [2:0] {
      StIdle,
      StSt,
      StOp,
      StPhyad,
      StRegad,
      StTa,
      StWdata,
      StRdata
   } state_t;

   state_t      r_state;
   logic [1:0]  r_mdc_s;
   logic [1:0]  r_mdio_s;
   logic        r_mdc_prev;
   logic [5:0]  r_ones;
   logic [3:0]  r_cnt;
   logic        r_op0;
   logic        r_is_rd;
   logic [3:0]  r_phy;
   logic [15:0] r_sr;
   logic        r_cap;
   logic        r_oe;
   logic        r_mdo;
   logic [4:0]  r_addr;
   logic [15:0] r_wdata;
   logic        r_wr;
   logic        r_rd;
   logic        r_err;

   logic        w_rise;
   logic        w_bit;
   logic [4:0]  w_phy_next;
   logic        w_accept;

   assign w_rise     = r_mdc_s[1] & ~r_mdc_prev;
   assign w_bit      = r_mdio_s[1];
   assign w_phy_next = {r_phy, w_bit};

`ifdef MDIO_RESP_BROADCAST_EN
   assign w_accept = (w_phy_next == PHY_ADDR) || ((w_phy_next == 5'h00) && !r_is_rd);
`else
   assign w_accept = (w_phy_next == PHY_ADDR);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= StIdle;
         r_mdc_s    <= 2'b00;
         r_mdio_s   <= 2'b00;
         r_mdc_prev <= 1'b0;
         r_ones     <= 6'd0;
         r_cnt      <= 4'd0;
         r_op0      <= 1'b0;
         r_is_rd    <= 1'b0;
         r_phy      <= 4'd0;
         r_sr       <= 16'd0;
         r_cap      <= 1'b0;
         r_oe       <= 1'b0;
         r_mdo      <= 1'b0;
         r_addr     <= 5'd0;
         r_wdata    <= 16'd0;
         r_wr       <= 1'b0;
         r_rd       <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_mdc_s    <= {r_mdc_s[0], mdc};
         r_mdio_s   <= {r_mdio_s[0], mdio};
         r_mdc_prev <= r_mdc_s[1];
         r_wr       <= 1'b0;
         r_rd       <= 1'b0;
         r_err      <= 1'b0;
         // Register file answers the cycle after reg_rd; capture it one clk later.
         r_cap      <= r_rd;
         if (r_cap) begin
            r_sr <= bus.reg_rdata;
         end
         if (w_rise) begin
            unique case (r_state)
               StIdle: begin
                  if (w_bit) begin
                     if (r_ones != 6'd32) begin
                        r_ones <= r_ones + 6'd1;
                     end
                  end else begin
                     r_ones <= 6'd0;
                     if (r_ones >= PreMin) begin
                        r_state <= StSt;
                     end
                  end
               end
               StSt: begin
                  r_cnt <= 4'd0;
                  if (w_bit) begin
                     r_state <= StOp;
                  end else begin
                     r_err   <= 1'b1;
                     r_state <= StIdle;
                  end
               end
               StOp: begin
                  if (r_cnt == 4'd0) begin
                     r_op0 <= w_bit;
                     r_cnt <= 4'd1;
                  end else begin
                     r_cnt <= 4'd0;
                     if (r_op0 != w_bit) begin
                        r_is_rd <= r_op0;
                        r_state <= StPhyad;
                     end else begin
                        r_err   <= 1'b1;
                        r_state <= StIdle;
                     end
                  end
               end
               StPhyad: begin
                  r_phy <= w_phy_next[3:0];
                  if (r_cnt == 4'd4) begin
                     r_cnt   <= 4'd0;
                     r_state <= w_accept ? StRegad : StIdle;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
               StRegad: begin
                  r_addr <= {r_addr[3:0], w_bit};
                  if (r_cnt == 4'd4) begin
                     r_cnt   <= 4'd0;
                     r_state <= StTa;
                     r_rd    <= r_is_rd;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
               StTa: begin
                  if (r_cnt == 4'd0) begin
                     r_cnt <= 4'd1;
                     if (r_is_rd) begin
                        r_oe  <= 1'b1;
                        r_mdo <= 1'b0;
                     end else if (!w_bit) begin
                        r_err   <= 1'b1;
                        r_state <= StIdle;
                     end
                  end else begin
                     r_cnt <= 4'd0;
                     if (r_is_rd) begin
                        r_mdo   <= r_sr[15];
                        r_sr    <= {r_sr[14:0], 1'b0};
                        r_state <= StRdata;
                     end else if (w_bit) begin
                        r_err   <= 1'b1;
                        r_state <= StIdle;
                     end else begin
                        r_state <= StWdata;
                     end
                  end
               end
               StWdata: begin
                  r_sr <= {r_sr[14:0], w_bit};
                  if (r_cnt == 4'd15) begin
                     r_wr    <= 1'b1;
                     r_wdata <= {r_sr[14:0], w_bit};
                     r_state <= StIdle;
                  end else begin
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
               StRdata: begin
                  if (r_cnt == 4'd15) begin
                     r_oe    <= 1'b0;
                     r_state <= StIdle;
                  end else begin
                     r_mdo <= r_sr[15];
                     r_sr  <= {r_sr[14:0], 1'b0};
                     r_cnt <= r_cnt + 4'd1;
                  end
               end
               default: r_state <= StIdle;
            endcase
         end
      end
   end

   assign mdio          = r_oe ? r_mdo : 1'bz;
   assign bus.reg_addr  = r_addr;
   assign bus.reg_wr    = r_wr;
   assign bus.reg_wdata = r_wdata;
   assign bus.reg_rd    = r_rd;
   assign bus.frame_err = r_err;
   assign bus.busy      = (r_state != StIdle);

endmodule

// File: tb/tb_mdio_responder.sv
// Directed bench for mdio_responder: table of MDIO frames plus reset-during-read sequence.
module tb_mdio_responder;

   logic clk;
   logic rst;
   logic mdc;
   logic tb_oe;
   logic tb_do;
   wire  mdio;

   mdio_responder_if bus_if ();

   assign mdio = tb_oe ? tb_do : 1'bz;
   pullup (mdio);

   mdio_responder #(
      .PHY_ADDR     (5'h01),
      .PREAMBLE_MIN (32)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .mdc  (mdc),
      .mdio (mdio),
      .bus  (bus_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   logic [15:0] rd_value;
   int          wr_cnt, rd_cnt, err_cnt, viol;
   logic [4:0]  wr_addr, rd_addr;
   logic [15:0] wr_data;
   int          n_checks, n_errors;

   // Synchronous register file: answers the clk after reg_rd.
   always @(posedge clk) begin
      bus_if.reg_rdata <= bus_if.reg_rd ? rd_value : 16'h0000;
   end

   initial begin
      wr_cnt = 0; rd_cnt = 0; err_cnt = 0; viol = 0;
      wr_addr = 5'd0; rd_addr = 5'd0; wr_data = 16'd0;
   end

   always @(negedge clk) begin
      if (bus_if.reg_wr) begin
         wr_cnt  <= wr_cnt + 1;
         wr_addr <= bus_if.reg_addr;
         wr_data <= bus_if.reg_wdata;
      end
      if (bus_if.reg_rd) begin
         rd_cnt  <= rd_cnt + 1;
         rd_addr <= bus_if.reg_addr;
      end
      if (bus_if.frame_err) err_cnt <= err_cnt + 1;
      if ((bus_if.reg_wr && bus_if.reg_rd) ||
          (bus_if.frame_err && (bus_if.reg_wr || bus_if.reg_rd))) viol <= viol + 1;
   end

   typedef struct {
      logic [1:0]  op;
      logic [4:0]  phy;
      logic [4:0]  regad;
      logic [15:0] data;
      int          pre;
      logic [1:0]  ta;
      int          exp_wr;
      int          exp_rd;
      int          exp_err;
      logic        exp_ta2;
      logic [15:0] exp_rbits;
   } vec_t;

   localparam int NVec = 12;
   vec_t vecs [NVec];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_bit(input logic b);
      tb_oe = 1'b1;
      tb_do = b;
      mdc   = 1'b0;
      repeat (4) @(posedge clk);
      #1 mdc = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic recv_bit(output logic b);
      tb_oe = 1'b0;
      mdc   = 1'b0;
      repeat (4) @(posedge clk);
      #1 b  = mdio;
      mdc   = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic send_header(input vec_t v);
      rd_value = v.data;
      repeat (v.pre) send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(v.op[1]);
      send_bit(v.op[0]);
      for (int i = 4; i >= 0; i--) send_bit(v.phy[i]);
      for (int i = 4; i >= 0; i--) send_bit(v.regad[i]);
   endtask

   task automatic run_frame(input vec_t v, output logic ta1, output logic ta2,
                            output logic [15:0] rbits, output logic post);
      logic b;
      ta1 = 1'b1; ta2 = 1'b1; rbits = 16'hFFFF; post = 1'b1;
      send_header(v);
      if (v.op == 2'b10) begin
         recv_bit(ta1);
         recv_bit(ta2);
         for (int i = 15; i >= 0; i--) begin
            recv_bit(b);
            rbits[i] = b;
         end
         recv_bit(post);
      end else begin
         send_bit(v.ta[1]);
         send_bit(v.ta[0]);
         for (int i = 15; i >= 0; i--) send_bit(v.data[i]);
      end
      tb_oe = 1'b0;
      repeat (12) @(posedge clk);
      #1;
   endtask

   initial begin
      logic        ta1, ta2, post, b;
      logic [15:0] rbits;
      int          w0, r0, e0;
      vec_t        rv;
      string       tag;

      n_checks = 0; n_errors = 0;
      rst = 1'b1; mdc = 1'b0; tb_oe = 1'b0; tb_do = 1'b1; rd_value = 16'h0;

      //         op     phy    regad  data      pre ta     wr rd er ta2   rbits
      vecs[0]  = '{2'b01, 5'h01, 5'h04, 16'h1234, 32, 2'b10, 1, 0, 0, 1'b1, 16'hFFFF};
      vecs[1]  = '{2'b10, 5'h01, 5'h01, 16'h796D, 32, 2'b10, 0, 1, 0, 1'b0, 16'h796D};
      vecs[2]  = '{2'b01, 5'h03, 5'h04, 16'h1234, 32, 2'b10, 0, 0, 0, 1'b1, 16'hFFFF};
      vecs[3]  = '{2'b10, 5'h03, 5'h01, 16'h796D, 32, 2'b10, 0, 0, 0, 1'b1, 16'hFFFF};
      vecs[4]  = '{2'b01, 5'h01, 5'h1F, 16'hA5C3, 32, 2'b10, 1, 0, 0, 1'b1, 16'hFFFF};
      vecs[5]  = '{2'b01, 5'h01, 5'h02, 16'h1234, 20, 2'b10, 0, 0, 0, 1'b1, 16'hFFFF};
      vecs[6]  = '{2'b01, 5'h01, 5'h06, 16'h0F0F, 32, 2'b10, 1, 0, 0, 1'b1, 16'hFFFF};
      vecs[7]  = '{2'b01, 5'h01, 5'h07, 16'h1234, 32, 2'b00, 0, 0, 1, 1'b1, 16'hFFFF};
`ifdef MDIO_RESP_BROADCAST_EN
      vecs[8]  = '{2'b01, 5'h00, 5'h09, 16'hBEEF, 32, 2'b10, 1, 0, 0, 1'b1, 16'hFFFF};
`else
      vecs[8]  = '{2'b01, 5'h00, 5'h09, 16'hBEEF, 32, 2'b10, 0, 0, 0, 1'b1, 16'hFFFF};
`endif
      vecs[9]  = '{2'b10, 5'h00, 5'h03, 16'h1111, 32, 2'b10, 0, 0, 0, 1'b1, 16'hFFFF};
      vecs[10] = '{2'b10, 5'h01, 5'h1E, 16'h8001, 32, 2'b10, 0, 1, 0, 1'b0, 16'h8001};
      vecs[11] = '{2'b11, 5'h01, 5'h05, 16'h1234, 32, 2'b10, 0, 0, 1, 1'b1, 16'hFFFF};

      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset busy", 32'(bus_if.busy), 32'd0);
      check("reset reg_addr", 32'(bus_if.reg_addr), 32'd0);
      check("reset reg_wdata", 32'(bus_if.reg_wdata), 32'd0);
      check("reset strobes", 32'({bus_if.reg_wr, bus_if.reg_rd, bus_if.frame_err}), 32'd0);
      check("reset mdio released", 32'(mdio), 32'd1);

      for (int k = 0; k < NVec; k++) begin
         w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
         run_frame(vecs[k], ta1, ta2, rbits, post);
         tag = $sformatf("v%0d", k);
         check({tag, " reg_wr count"}, 32'(wr_cnt - w0), 32'(vecs[k].exp_wr));
         check({tag, " reg_rd count"}, 32'(rd_cnt - r0), 32'(vecs[k].exp_rd));
         check({tag, " frame_err count"}, 32'(err_cnt - e0), 32'(vecs[k].exp_err));
         check({tag, " busy after"}, 32'(bus_if.busy), 32'd0);
         check({tag, " mdio released after"}, 32'(mdio), 32'd1);
         if (vecs[k].exp_wr != 0) begin
            check({tag, " wr addr"}, 32'(wr_addr), 32'(vecs[k].regad));
            check({tag, " wr data"}, 32'(wr_data), 32'(vecs[k].data));
         end
         if (vecs[k].exp_rd != 0) check({tag, " rd addr"}, 32'(rd_addr), 32'(vecs[k].regad));
         if (vecs[k].op == 2'b10) begin
            check({tag, " ta1 released"}, 32'(ta1), 32'd1);
            check({tag, " ta2"}, 32'(ta2), 32'(vecs[k].exp_ta2));
            check({tag, " read bits"}, 32'(rbits), 32'(vecs[k].exp_rbits));
            check({tag, " released after data"}, 32'(post), 32'd1);
         end
      end

      // Reset while the responder drives the sixth data bit (0 for 0x796D).
      rv = vecs[1];
      send_header(rv);
      recv_bit(ta1);
      recv_bit(ta2);
      rbits = 16'h0;
      for (int i = 0; i < 5; i++) begin
         recv_bit(b);
         rbits[4 - i] = b;
      end
      check("abort first bits", 32'(rbits[4:0]), 32'h0F);
      mdc = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("abort bit5 driven", 32'(mdio), 32'd0);
      check("abort busy before rst", 32'(bus_if.busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      check("rst mdio released", 32'(mdio), 32'd1);
      check("rst busy", 32'(bus_if.busy), 32'd0);
      repeat (10) @(posedge clk);
      #1;
      w0 = wr_cnt; r0 = rd_cnt; e0 = err_cnt;
      run_frame(rv, ta1, ta2, rbits, post);
      check("post-rst ta2", 32'(ta2), 32'd0);
      check("post-rst read bits", 32'(rbits), 32'h796D);
      check("post-rst reg_rd count", 32'(rd_cnt - r0), 32'd1);
      check("post-rst no write/err", 32'((wr_cnt - w0) + (err_cnt - e0)), 32'd0);
      check("strobe exclusivity", 32'(viol), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL timeout: simulation exceeded its time limit");
      $fatal(1, "timeout");
   end

endmodule
